neuron_accumulator: RTL and testbench

- Sequential accumulator directly downstream of the fixed-point sign-magnitude multiplier.
- Consumes a stream of weighted-input products (Q12.20, sign-magnitude, with per-product overflow flag) and sums them exactly in two's complement.
- Adds a bias, optionally applies ReLU, saturates, and emits one sign-magnitude neuron output per burst, ready to feed the next layer's multipliers.

---
 rtl/neuron_accumulator.sv | 121 ++++++++++++
 tb/tb_neuron_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - exact sign-magnitude product accumulator with bias, optional ReLU and saturation
module neuron_accumulator #(
   parameter int n         = 32,
   parameter int intbits   = 12,
   parameter int fracbits  = 20,
   parameter int MAX_TERMS = 16,
   parameter int RELU      = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] in_product,
   input  logic         in_ovf,
   input  logic         in_last,
   input  logic [n-1:0] bias,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] out_result,
   output logic         out_ovf
);
   localparam int G    = $clog2(MAX_TERMS + 1);
   localparam int ACCW = n + G + 1;

   // The Q split only documents the format; the datapath never looks at it.
   if (intbits + fracbits != n) begin : g_q_format_non_canonical
   end

   typedef enum logic [1:0] {ACCUM, BIAS, DONE} state_t;

   state_t                 state;
   logic signed [ACCW-1:0] acc;
   logic [G-1:0]           count;
   logic                   sticky;

   logic                   accept;
   logic signed [ACCW-1:0] biased_sum;
   logic signed [ACCW-1:0] abs_sum;
   logic                   sum_neg;
   logic                   too_big;
   logic [n-1:0]           res_word;
   logic                   res_ovf;

   function automatic logic signed [ACCW-1:0] conv(input logic [n-1:0] x);
      logic signed [ACCW-1:0] mag;
      mag = $signed({{(G + 2){1'b0}}, x[n-2:0]});
      return x[n-1] ? -mag : mag;
   endfunction

   assign accept = in_valid & in_ready;

   always_comb begin
      biased_sum = acc + conv(bias);
      sum_neg    = biased_sum[ACCW-1];
      abs_sum    = sum_neg ? -biased_sum : biased_sum;
      too_big    = |abs_sum[ACCW-1:n-1];
      res_word   = '0;
      res_ovf    = sticky;
      if (RELU != 0 && sum_neg) begin
         res_word = '0;
      end else if (too_big) begin
         res_word = {sum_neg, {(n - 1){1'b1}}};
         res_ovf  = 1'b1;
      end else begin
         res_word = {sum_neg, abs_sum[n-2:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACCUM;
         acc        <= '0;
         count      <= '0;
         sticky     <= 1'b0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_ovf    <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               in_ready <= 1'b1;
               if (accept) begin
                  acc <= acc + conv(in_product);
                  // Past MAX_TERMS the guard bits no longer cover the sum, so flag it.
                  if (count == G'(MAX_TERMS)) begin
                     sticky <= 1'b1;
                  end else begin
                     count  <= count + 1'b1;
                     sticky <= sticky | in_ovf;
                  end
                  if (in_last) begin
                     in_ready <= 1'b0;
                     state    <= BIAS;
                  end
               end
            end
            BIAS: begin
               acc        <= biased_sum;
               out_result <= res_word;
               out_ovf    <= res_ovf;
               out_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  acc       <= '0;
                  count     <= '0;
                  sticky    <= 1'b0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACCUM;
               end
            end
            default: begin
               state <= ACCUM;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - directed bench for neuron_accumulator (RELU=0 and RELU=1 in lockstep)
module tb_neuron_accumulator;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_product;
   logic        in_ovf;
   logic        in_last;
   logic [31:0] bias;
   logic        out_ready;
   logic        in_ready, out_valid, out_ovf;
   logic [31:0] out_result;
   logic        r_in_ready, r_out_valid, r_out_ovf;
   logic [31:0] r_out_result;

   int checks = 0;
   int errors = 0;

   neuron_accumulator #(.n(32), .intbits(12), .fracbits(20), .MAX_TERMS(16), .RELU(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_product(in_product), .in_ovf(in_ovf), .in_last(in_last), .bias(bias),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf)
   );

   neuron_accumulator #(.n(32), .intbits(12), .fracbits(20), .MAX_TERMS(16), .RELU(1)) dut_relu (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
      .in_product(in_product), .in_ovf(in_ovf), .in_last(in_last), .bias(bias),
      .out_valid(r_out_valid), .out_ready(out_ready), .out_result(r_out_result), .out_ovf(r_out_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic wait_ready(input string name);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      end
   endtask

   task automatic send(input logic [31:0] p, input logic ovf, input logic last);
      in_valid   = 1'b1;
      in_product = p;
      in_ovf     = ovf;
      in_last    = last;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_ovf     = 1'b0;
      in_last    = 1'b0;
   endtask

   task automatic get_result(input string name, input logic [31:0] exp, input logic exp_ovf,
                             input logic [31:0] exp_r, input logic exp_r_ovf);
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      checks++;
      if (out_valid !== 1'b1 || r_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s out_valid: got %b/%b want 1/1", name, out_valid, r_out_valid);
      end
      checks++;
      if (out_result !== exp || out_ovf !== exp_ovf) begin
         errors++;
         $display("FAIL %s result: got %h ovf %b want %h ovf %b", name, out_result, out_ovf, exp, exp_ovf);
      end
      checks++;
      if (r_out_result !== exp_r || r_out_ovf !== exp_r_ovf) begin
         errors++;
         $display("FAIL %s relu result: got %h ovf %b want %h ovf %b", name, r_out_result, r_out_ovf, exp_r, exp_r_ovf);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: got rdy %b vld %b res %h ovf %b want 0 0 0 0", in_ready, out_valid, out_result, out_ovf);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_burst();
      wait_ready("mid_reset pre");
      bias = 32'h0;
      send(32'h00100000, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'h0 || out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset outputs: got rdy %b vld %b res %h ovf %b want 0 0 0 0", in_ready, out_valid, out_result, out_ovf);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ready("mid_reset post");
      send(32'h00200000, 1'b0, 1'b1);
      get_result("mid_reset burst", 32'h00200000, 1'b0, 32'h00200000, 1'b0);
   endtask

   task automatic test_signed_sum();
      wait_ready("signed");
      bias = 32'h80100000;
      send(32'h00180000, 1'b0, 1'b0);
      send(32'h80080000, 1'b0, 1'b0);
      send(32'h00040000, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL signed latency early: got out_valid %b want 0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL signed latency: got out_valid %b want 1", out_valid);
      end
      get_result("signed", 32'h00040000, 1'b0, 32'h00040000, 1'b0);
   endtask

   task automatic test_saturation();
      wait_ready("sat_pos");
      bias = 32'h0;
      for (int i = 0; i < 4; i++) send(32'h7FF00000, 1'b0, i == 3);
      get_result("sat_pos", 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1);
      wait_ready("sat_neg");
      for (int i = 0; i < 4; i++) send(32'hFFF00000, 1'b0, i == 3);
      get_result("sat_neg", 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0);
      wait_ready("max_exact");
      send(32'h7FFFFFFF, 1'b0, 1'b1);
      get_result("max_exact", 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0);
   endtask

   task automatic test_relu_negzero();
      wait_ready("relu");
      bias = 32'h00100000;
      send(32'h80300000, 1'b0, 1'b1);
      get_result("relu", 32'h80200000, 1'b0, 32'h00000000, 1'b0);
      wait_ready("negzero");
      bias = 32'h80000000;
      send(32'h00100000, 1'b0, 1'b0);
      send(32'h80100000, 1'b0, 1'b1);
      get_result("negzero", 32'h00000000, 1'b0, 32'h00000000, 1'b0);
   endtask

   task automatic test_ovf_propagation();
      wait_ready("ovf_sticky");
      bias = 32'h0;
      send(32'h00100000, 1'b0, 1'b0);
      send(32'h00100000, 1'b1, 1'b0);
      send(32'h00100000, 1'b0, 1'b1);
      get_result("ovf_sticky", 32'h00300000, 1'b1, 32'h00300000, 1'b1);
      wait_ready("ovf_cleared");
      send(32'h00100000, 1'b0, 1'b1);
      get_result("ovf_cleared", 32'h00100000, 1'b0, 32'h00100000, 1'b0);
   endtask

   task automatic test_term_limit();
      wait_ready("terms16");
      bias = 32'h0;
      for (int i = 0; i < 16; i++) send(32'h00000001, 1'b0, i == 15);
      get_result("terms16", 32'h00000010, 1'b0, 32'h00000010, 1'b0);
      wait_ready("terms17");
      for (int i = 0; i < 17; i++) send(32'h00000001, 1'b0, i == 16);
      get_result("terms17", 32'h00000011, 1'b1, 32'h00000011, 1'b1);
   endtask

   task automatic test_back_pressure();
      wait_ready("bp");
      bias = 32'h0;
      send(32'h00050000, 1'b0, 1'b1);
      @(posedge clk); #1;
      in_valid   = 1'b1;
      in_product = 32'h00700000;
      in_last    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h00050000) begin
            errors++;
            $display("FAIL bp hold %0d: got rdy %b vld %b res %h want 0 1 00050000", i, in_ready, out_valid, out_result);
         end
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp release: got vld %b rdy %b want 0 1", out_valid, in_ready);
      end
   endtask

   initial begin
      clk        = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_product = 32'h0;
      in_ovf     = 1'b0;
      in_last    = 1'b0;
      bias       = 32'h0;
      out_ready  = 1'b0;
      test_reset();
      test_reset_mid_burst();
      test_signed_sum();
      test_saturation();
      test_relu_negzero();
      test_ovf_propagation();
      test_term_limit();
      test_back_pressure();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
